// File: rtl/vga_if.sv
// Pixel-side signal bundle of the VGA timing controller: colour select in, syncs and colour out.
interface vga_if;
  logic [1:0] inRGB;
  logic       HSync;
  logic       VSync;
  logic [2:0] RGB;

  modport master (
    input  inRGB,
    output HSync,
    output VSync,
    output RGB
  );

  modport slave (
    output inRGB,
    input  HSync,
    input  VSync,
    input  RGB
  );
endinterface

// File: rtl/vga_controller.sv
// VGA raster timing generator: free-running pixel/line counters with registered
// active-low syncs and a colour-mapped RGB output.
module vga_controller #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic clk,
  input  logic rst,
  vga_if.master bus
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = ($clog2(H_TOTAL) > 10) ? $clog2(H_TOTAL) : 10;
  localparam int VW = ($clog2(V_TOTAL) > 10) ? $clog2(V_TOTAL) : 10;

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_FIRST   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_LAST    = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_FIRST   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_LAST    = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  function automatic logic [2:0] map_colour(input logic [1:0] code);
    logic [2:0] colour;
    case (code)
      2'b00:   colour = 3'b000;
      2'b01:   colour = 3'b100;
      2'b10:   colour = 3'b010;
      2'b11:   colour = 3'b111;
      default: colour = 3'b000;
    endcase
    return colour;
  endfunction

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic [2:0]    rgb_q, rgb_d;
  logic          active_s;

  // Next counter position and the pins for the pixel the counters hold now.
  always_comb begin
    hcnt_d   = hcnt_q;
    vcnt_d   = vcnt_q;
    hsync_d  = 1'b1;
    vsync_d  = 1'b1;
    rgb_d    = 3'b000;
    active_s = (hcnt_q < H_ACT_END) && (vcnt_q < V_ACT_END);

    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      if (vcnt_q == V_LAST) begin
        vcnt_d = '0;
      end else begin
        vcnt_d = vcnt_q + VW'(1);
      end
    end else begin
      hcnt_d = hcnt_q + HW'(1);
    end

    if ((hcnt_q >= HS_FIRST) && (hcnt_q <= HS_LAST)) begin
      hsync_d = 1'b0;
    end else begin
      hsync_d = 1'b1;
    end

    if ((vcnt_q >= VS_FIRST) && (vcnt_q <= VS_LAST)) begin
      vsync_d = 1'b0;
    end else begin
      vsync_d = 1'b1;
    end

    if (active_s) begin
      rgb_d = map_colour(bus.inRGB);
    end else begin
      rgb_d = 3'b000;
    end
  end

  // Counter and output registers; reset parks the raster at (0,0) with syncs idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      rgb_q   <= 3'b000;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      rgb_q   <= rgb_d;
    end
  end

  assign bus.HSync = hsync_q;
  assign bus.VSync = vsync_q;
  assign bus.RGB   = rgb_q;

endmodule

// File: tb/tb_vga_controller.sv
// Directed bench: default 640x480 timing for reset, colour map, blanking and hsync;
// a shrunken geometry instance for full-frame vsync and wrap behaviour.
module tb_vga_controller;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic rst_s = 1'b1;
  int checks  = 0;
  int passed  = 0;
  int fails   = 0;

  always #20 clk = ~clk;

  vga_if bus ();
  vga_if bus_s ();

  vga_controller dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  vga_controller #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) dut_s (
    .clk (clk),
    .rst (rst_s),
    .bus (bus_s)
  );

  function automatic logic [2:0] colour_of(input logic [1:0] code);
    logic [2:0] c;
    case (code)
      2'b00:   c = 3'b000;
      2'b01:   c = 3'b100;
      2'b10:   c = 3'b010;
      default: c = 3'b111;
    endcase
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected pins for pixel index p counted from reset release.
  task automatic check_pix(input string tag, input int p,
                           input int ha, input int hfp, input int hsy, input int hbp,
                           input int va, input int vfp, input int vsy, input int vbp,
                           input logic hs, input logic vs, input logic [2:0] rgb,
                           input logic [1:0] code);
    int ht, vt, h, v;
    logic e_hs, e_vs;
    logic [2:0] e_rgb;
    ht = ha + hfp + hsy + hbp;
    vt = va + vfp + vsy + vbp;
    h  = p % ht;
    v  = (p / ht) % vt;
    e_hs  = !((h >= ha + hfp) && (h < ha + hfp + hsy));
    e_vs  = !((v >= va + vfp) && (v < va + vfp + vsy));
    e_rgb = ((h < ha) && (v < va)) ? colour_of(code) : 3'b000;
    check($sformatf("%s_hs_h%0d_v%0d", tag, h, v), 32'(hs), 32'(e_hs));
    check($sformatf("%s_vs_h%0d_v%0d", tag, h, v), 32'(vs), 32'(e_vs));
    check($sformatf("%s_rgb_h%0d_v%0d", tag, h, v), 32'(rgb), 32'(e_rgb));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] codes [4];
    logic [2:0] want  [4];
    logic [1:0] c;
    int low_start, low_len;
    codes = '{2'b00, 2'b01, 2'b10, 2'b11};
    want  = '{3'b000, 3'b100, 3'b010, 3'b111};
    bus.inRGB   = 2'b11;
    bus_s.inRGB = 2'b00;

    // Reset state while clock runs.
    repeat (3) step();
    check("rst_hs", 32'(bus.HSync), 32'd1);
    check("rst_vs", 32'(bus.VSync), 32'd1);
    check("rst_rgb", 32'(bus.RGB), 32'd0);
    check("rst_hcnt", 32'(dut.hcnt_q), 32'd0);
    check("rst_vcnt", 32'(dut.vcnt_q), 32'd0);

    // Colour map on the first four pixels of line 0.
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.inRGB = codes[i];
      step();
      check($sformatf("cmap_%0d", i), 32'(bus.RGB), 32'(want[i]));
      if (i == 0) begin
        check("first_hcnt", 32'(dut.hcnt_q), 32'd1);
        check("first_hs", 32'(bus.HSync), 32'd1);
      end
    end

    // Line 0 with constant white, then varying codes until hcnt reaches 700 on line 2.
    low_start = -1;
    low_len   = 0;
    for (int p = 4; p < 2300; p++) begin
      c = (p < 800) ? 2'b11 : 2'(p % 4);
      bus.inRGB = c;
      step();
      check_pix("dflt", p, 640, 16, 96, 48, 480, 10, 2, 33, bus.HSync, bus.VSync, bus.RGB, c);
      if (bus.HSync == 1'b0 && p < 800) begin
        if (low_start < 0) low_start = p + 1;
        low_len++;
      end
    end
    check("hs_first_low_edge", 32'(low_start), 32'd657);
    check("hs_low_len", 32'(low_len), 32'd96);
    check("pre_rst_hcnt", 32'(dut.hcnt_q), 32'd700);
    check("pre_rst_hs", 32'(bus.HSync), 32'd0);

    // Asynchronous reset between edges during the sync pulse.
    #5;
    rst = 1'b1;
    #1;
    check("arst_hs", 32'(bus.HSync), 32'd1);
    check("arst_vs", 32'(bus.VSync), 32'd1);
    check("arst_rgb", 32'(bus.RGB), 32'd0);
    check("arst_hcnt", 32'(dut.hcnt_q), 32'd0);
    check("arst_vcnt", 32'(dut.vcnt_q), 32'd0);
    step();

    // Small geometry: 16x9 raster, 144 clocks per frame, run past two wraps.
    rst_s = 1'b0;
    low_start = -1;
    low_len   = 0;
    for (int p = 0; p < 310; p++) begin
      c = 2'((p * 3 + p / 7) % 4);
      bus_s.inRGB = c;
      step();
      check_pix("small", p, 8, 2, 3, 3, 4, 1, 2, 2, bus_s.HSync, bus_s.VSync, bus_s.RGB, c);
      if (bus_s.VSync == 1'b0 && p < 144) begin
        if (low_start < 0) low_start = p;
        low_len++;
      end
    end
    check("vs_first_low_pixel", 32'(low_start), 32'd80);
    check("vs_low_len", 32'(low_len), 32'd32);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/vga_controller.md
VGA_CONTROLLER -- requirements
Module: vga_controller

Interface
REQ-001 Parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 Parameter H_FP, default 16: horizontal front porch, in clocks.
REQ-003 Parameter H_SYNC, default 96: horizontal sync pulse width, in clocks.
REQ-004 Parameter H_BP, default 48: horizontal back porch, in clocks.
REQ-005 Parameter V_ACTIVE, default 480: visible lines per frame.
REQ-006 Parameter V_FP, default 10: vertical front porch, in lines.
REQ-007 Parameter V_SYNC, default 2: vertical sync pulse width, in lines.
REQ-008 Parameter V_BP, default 33: vertical back porch, in lines.
REQ-009 clk  input  1  pixel clock, 25 MHz nominal (40 ns period), rising-edge active.
REQ-010 rst  input  1  reset, asynchronous, active-high.
REQ-011 inRGB  input  2  colour select code.
REQ-012 HSync  output  1  horizontal sync, active-low, registered.
REQ-013 VSync  output  1  vertical sync, active-low, registered.
REQ-014 RGB  output  3  pixel colour {R,G,B}, registered.

Function
REQ-015 The block SHALL hold an internal horizontal counter hcnt.
- Range 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
- Increments by 1 on every rising clk edge while rst=0.
REQ-016 hcnt SHALL wrap from H_TOTAL-1 to 0.
REQ-017 The block SHALL hold an internal vertical counter vcnt.
- Range 0..V_TOTAL-1, where V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Increments only on the edge where hcnt wraps.
- Wraps from V_TOTAL-1 to 0 on the same edge hcnt wraps; a frame is 420000 clocks.
REQ-018 Each line SHALL be ordered active, front porch, sync, back porch; each frame likewise.
REQ-019 On each rising edge, outputs SHALL be computed from the (hcnt, vcnt) values held before that edge, giving one clock of latency from counter to pins.
REQ-020 HSync SHALL be 0 when hcnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751), else 1.
REQ-021 VSync SHALL be 0 when vcnt is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491), else 1, for all hcnt in those lines.
REQ-022 Active video SHALL be hcnt<H_ACTIVE and vcnt<V_ACTIVE.
REQ-023 During active video, RGB SHALL be loaded from the inRGB value sampled at that edge, using this map:
- 00 -> 000 (black)
- 01 -> 100 (red)
- 10 -> 010 (green)
- 11 -> 111 (white)
REQ-024 Outside active video, RGB SHALL be 000 regardless of inRGB.
REQ-025 inRGB changes SHALL take effect on the next rising edge, with no pipeline beyond REQ-019.
REQ-026 Counter widths SHALL be at least 10 bits; no counter value outside its range is ever reachable.

Reset
REQ-027 While rst=1, asynchronously and regardless of clk, the block SHALL force:
- hcnt=0, vcnt=0
- HSync=1, VSync=1
- RGB=000
REQ-028 Reset asserted mid-line or mid-frame SHALL abort the frame; no partial sync pulse continues after rst rises.
REQ-029 On the first rising edge after rst falls, outputs SHALL reflect pixel (0,0) and hcnt SHALL become 1.

Verification
REQ-030 Async reset: assert rst between clock edges while HSync=0 (hcnt=700) -> HSync=1, VSync=1, RGB=000 before the next edge; counters read 0.
REQ-031 Colour map: after reset, drive inRGB=00, 01, 10, 11 on successive edges within the first 640 pixels of line 0 -> RGB=000, 100, 010, 111, each one edge after application.
REQ-032 Blanking: inRGB=11 held constant -> RGB=111 for 640 clocks, then 000 for 160 clocks, per line in lines 0..479; RGB=000 for all of lines 480..524.
REQ-033 HSync timing: from reset release -> HSync first goes 0 at the 657th rising edge, stays 0 for 96 clocks, and repeats every 800 clocks.
REQ-034 VSync timing: VSync goes 0 at the edge that outputs pixel (0,490), stays 0 for exactly 1600 clocks, and repeats every 420000 clocks; HSync keeps toggling during VSync.
REQ-035 Wrap: at pixel (799,524) the next edge outputs pixel (0,0) -> RGB follows inRGB again and the frame sequence restarts identically.
